traffic_sender: RTL and testbench
=================================

# traffic_sender

Testbench traffic source that sits directly upstream of the PIFO under test and is the counterpart of the traffic receiver on the dequeue side. During the inject phase it draws an LFSR-based Bernoulli trial each free cycle to decide whether to create a packet. Created packets carry sequential pointers and LFSR-random, masked priorities. Each packet is held in a one-entry pending register and offered to the PIFO enqueue port under a ready handshake. The block stops after a configured packet count and reports completion.

## Interface
- No parameters; all widths come from the shared testbench package types.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- i__config  in  TSConfig  fields: injrate (InjectionRate), injrate_seed (InjectionRate), prio_seed (Priority), prio_mask (Priority), num_pkts (CounterSignal)
- i__inject_phase  in  1  injection permitted while high
- i__pifo_ready  in  1  PIFO can accept an enqueue this cycle
- o__enqueue  out  1  enqueue strobe; one packet transferred per cycle it is high
- o__packet_pointer  out  PacketPointer  pointer of the pending packet
- o__packet_priority  out  Priority  priority of the pending packet
- o__num_pkts_sent  out  CounterSignal  count of completed enqueues
- o__done  out  1  all num_pkts enqueued

## Operation
- FSM states: IDLE, INJECT, DONE. Reset → IDLE.
- IDLE → INJECT when i__inject_phase=1 and num_pkts≠0.
- IDLE → DONE when i__inject_phase=1 and num_pkts=0.
- INJECT → IDLE when i__inject_phase=0. This is a pause: counters and the pending packet are kept, and the pending packet is still offered.
- INJECT → DONE when gen_count==num_pkts and the pending register is empty, including the cycle its last enqueue completes.
- DONE is sticky until reset.
- Slot free = !pend_valid || o__enqueue.
- Draw: the injection LFSR value, updated only when state==INJECT and the slot is free.
- Hit = (draw < injrate) || (injrate == all-ones). The all-ones injrate gives a full-rate mode. injrate=0 never hits.
- Generate = state==INJECT && slot free && hit && gen_count<num_pkts. On generate:
  - pend_valid←1
  - pointer←gen_count truncated to PacketPointer width (wraps modulo 2^width)
  - priority←prio_lfsr & prio_mask
  - prio LFSR advances
  - gen_count+1
- o__enqueue = pend_valid && i__pifo_ready. This is combinational from registered state plus ready.
- On enqueue without a same-cycle generate, pend_valid←0. o__num_pkts_sent increments by 1.
- Simultaneous enqueue and generate: the pending register is overwritten with the new packet and pend_valid stays 1, so back-to-back enqueues are possible every cycle.
- While pend_valid=1 and ready=0: pointer and priority held stable, no draw, no LFSR advance.
- Counters are CounterSignal width; num_pkts is bounded by the config, so no counter wrap.

## Timing
- Reset values: o__enqueue=0, o__packet_pointer=0, o__packet_priority=0, o__num_pkts_sent=0, o__done=0, gen_count=0, pend_valid=0. Both LFSRs load their seeds.
- Reset mid-operation discards the pending packet and all counts in one cycle.
- State INJECT is entered the cycle after i__inject_phase rises, and the first draw is made in that cycle.
- Latency: a generate in cycle N makes the packet visible in cycle N+1, with enqueue earliest in N+1.
- o__done is registered and asserts the cycle after the transition into DONE.
- With i__inject_phase low and a pending packet, an enqueue can still occur in IDLE. Injection does not resume until the phase is high again.

## Structure
- Shared testbench package (common_tb_headers.vh) gains the TSConfig struct. It reuses PacketPointer, Priority, InjectionRate and CounterSignal.
- Reuse the existing linear_feedback_shift_register twice:
  - NUM_BITS=$bits(InjectionRate), i__next=draw enable, seed injrate_seed
  - NUM_BITS=$bits(Priority), i__next=generate, seed prio_seed
- FSM, pending register and counters live in this module.

## Test plan
- num_pkts=16, injrate=all-ones, prio_mask=all-ones, ready=1, phase=1 → 16 consecutive enqueue cycles, pointers 0..15, o__num_pkts_sent=16, o__done=1 two cycles after the last enqueue.
- injrate=0, num_pkts=8, 1000 cycles in phase → o__enqueue never high, o__num_pkts_sent=0, o__done=0.
- Full rate, ready low for 10 cycles after the first packet → pointer 0 and its priority stay stable, enqueue=0, sent=0. When ready rises, enqueues resume with pointer 0 and then 1.
- prio_mask=0x3, 64 packets → every priority ≤3 and matches a reference LFSR model advanced only on generates.
- num_pkts=0 with phase high → DONE next cycle, o__done=1 one cycle later, no enqueue.
- Phase dropped after 5 of 10 packets, then re-raised → gen_count holds at 5. Pointers continue 5..9 with no duplicate or skip.
- Reset asserted mid-run with a packet pending → all outputs return to their reset values the next cycle.

Source files
------------

// File: rtl/traffic_sender_pkg.sv
// Shared testbench types for the PIFO traffic endpoints, plus LFSR tap selection.
package traffic_sender_pkg;

  typedef logic [7:0]  PacketPointer;
  typedef logic [7:0]  Priority;
  typedef logic [7:0]  InjectionRate;
  typedef logic [15:0] CounterSignal;

  typedef struct packed {
    InjectionRate injrate;
    InjectionRate injrate_seed;
    Priority      prio_seed;
    Priority      prio_mask;
    CounterSignal num_pkts;
  } TSConfig;

  typedef enum logic [1:0] {IDLE, INJECT, DONE} ts_state_e;

  // Maximal-length Fibonacci taps; bit i set means stage i feeds back.
  function automatic logic [15:0] lfsr_taps(input int unsigned n);
    case (n)
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      12:      return 16'h0E08;
      16:      return 16'hB400;
      default: return 16'h00B8;
    endcase
  endfunction

endpackage

// File: rtl/linear_feedback_shift_register.sv
// Fibonacci LFSR: loads its seed in reset, shifts one step per i__next.
module linear_feedback_shift_register
  import traffic_sender_pkg::*;
#(
  parameter int unsigned NUM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i__next,
  input  logic [NUM_BITS-1:0] i__seed,
  output logic [NUM_BITS-1:0] o__vector
);

  localparam logic [15:0]         TAPS_W = lfsr_taps(NUM_BITS);
  localparam logic [NUM_BITS-1:0] TAPS   = TAPS_W[NUM_BITS-1:0];

  logic feedback;
  assign feedback = ^(o__vector & TAPS);

  // A zero seed locks the register at zero; callers supply a nonzero seed.
  always_ff @(posedge clk) begin
    if (reset)        o__vector <= i__seed;
    else if (i__next) o__vector <= {o__vector[NUM_BITS-2:0], feedback};
  end

endmodule

// File: rtl/traffic_sender.sv
// Bernoulli traffic source feeding the PIFO enqueue port through a
// one-entry pending register under a ready handshake.
module traffic_sender
  import traffic_sender_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  TSConfig      i__config,
  input  logic         i__inject_phase,
  input  logic         i__pifo_ready,
  output logic         o__enqueue,
  output PacketPointer o__packet_pointer,
  output Priority      o__packet_priority,
  output CounterSignal o__num_pkts_sent,
  output logic         o__done
);

  ts_state_e    state, state_nxt;
  logic         pend_valid;
  CounterSignal gen_count;
  InjectionRate draw;
  Priority      prio_rnd;
  logic         slot_free, draw_en, hit, gen_pkt, all_out;

  assign o__enqueue = pend_valid && i__pifo_ready;
  assign slot_free  = !pend_valid || o__enqueue;
  assign draw_en    = (state == INJECT) && slot_free;
  assign hit        = (draw < i__config.injrate) || (&i__config.injrate);
  assign gen_pkt    = draw_en && hit && (gen_count < i__config.num_pkts);
  // Also true in the cycle the final packet leaves the pending register.
  assign all_out    = (gen_count == i__config.num_pkts) && slot_free;

  linear_feedback_shift_register #(.NUM_BITS($bits(InjectionRate))) u_inj_lfsr (
    .clk       (clk),
    .reset     (reset),
    .i__next   (draw_en),
    .i__seed   (i__config.injrate_seed),
    .o__vector (draw)
  );

  linear_feedback_shift_register #(.NUM_BITS($bits(Priority))) u_prio_lfsr (
    .clk       (clk),
    .reset     (reset),
    .i__next   (gen_pkt),
    .i__seed   (i__config.prio_seed),
    .o__vector (prio_rnd)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:
        if (i__inject_phase)
          state_nxt = (i__config.num_pkts == '0) ? DONE : INJECT;
      INJECT:
        if (all_out)               state_nxt = DONE;
        else if (!i__inject_phase) state_nxt = IDLE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      pend_valid         <= 1'b0;
      gen_count          <= '0;
      o__packet_pointer  <= '0;
      o__packet_priority <= '0;
      o__num_pkts_sent   <= '0;
      o__done            <= 1'b0;
    end else begin
      state   <= state_nxt;
      o__done <= (state == DONE);
      // A same-cycle generate overwrites the slot being enqueued.
      if (gen_pkt) begin
        pend_valid         <= 1'b1;
        o__packet_pointer  <= PacketPointer'(gen_count);
        o__packet_priority <= prio_rnd & i__config.prio_mask;
        gen_count          <= gen_count + CounterSignal'(1);
      end else if (o__enqueue) begin
        pend_valid <= 1'b0;
      end
      if (o__enqueue) o__num_pkts_sent <= o__num_pkts_sent + CounterSignal'(1);
    end
  end

endmodule

// File: tb/tb_traffic_sender.sv
// Directed bench for traffic_sender: full rate, zero rate, backpressure,
// masked priorities, empty run, phase pause and mid-run reset.
module tb_traffic_sender;
  import traffic_sender_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  TSConfig      cfg;
  logic         phase, ready;
  logic         enq, done;
  PacketPointer ptr;
  Priority      prio;
  CounterSignal sent;

  int n_tests = 0;
  int n_fail  = 0;
  int enq_n   = 0;
  PacketPointer ptr_q[$];
  Priority      prio_q[$];

  traffic_sender dut (
    .clk                (clk),
    .reset              (reset),
    .i__config          (cfg),
    .i__inject_phase    (phase),
    .i__pifo_ready      (ready),
    .o__enqueue         (enq),
    .o__packet_pointer  (ptr),
    .o__packet_priority (prio),
    .o__num_pkts_sent   (sent),
    .o__done            (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && enq) begin
      ptr_q.push_back(ptr);
      prio_q.push_back(prio);
      enq_n++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    phase = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    ptr_q.delete();
    prio_q.delete();
    enq_n = 0;
  endtask

  function automatic Priority lfsr8(input Priority s);
    return {s[6:0], ^(s & 8'hB8)};
  endfunction

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk(tag, done, 1);
  endtask

  initial begin
    Priority ref_p;
    int      bad;

    reset = 1'b1;
    phase = 1'b0;
    ready = 1'b0;

    // Full rate, 16 packets back to back
    cfg = '{injrate: 8'hFF, injrate_seed: 8'h5A, prio_seed: 8'h3C,
            prio_mask: 8'hFF, num_pkts: 16'd16};
    do_reset();
    chk("rst_enq", enq, 0);
    chk("rst_ptr", ptr, 0);
    chk("rst_prio", prio, 0);
    chk("rst_sent", sent, 0);
    chk("rst_done", done, 0);
    ready = 1'b1;
    phase = 1'b1;
    repeat (17) tick();
    chk("full_last_enq", enq, 1);
    chk("full_last_ptr", ptr, 15);
    tick();
    chk("full_after_enq", enq, 0);
    chk("full_done_early", done, 0);
    chk("full_sent", sent, 16);
    tick();
    chk("full_done", done, 1);
    chk("full_count", ptr_q.size(), 16);
    ref_p = 8'h3C;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("full_ptr%0d", i), ptr_q[i], i);
      chk($sformatf("full_prio%0d", i), prio_q[i], ref_p);
      ref_p = lfsr8(ref_p);
    end

    // Zero rate never injects
    cfg.injrate  = 8'h00;
    cfg.num_pkts = 16'd8;
    do_reset();
    phase = 1'b1;
    repeat (1000) tick();
    chk("zero_enq_n", enq_n, 0);
    chk("zero_sent", sent, 0);
    chk("zero_done", done, 0);

    // Backpressure holds the first packet stable
    cfg.injrate  = 8'hFF;
    cfg.num_pkts = 16'd4;
    do_reset();
    ready = 1'b0;
    phase = 1'b1;
    tick();
    tick();
    chk("bp_ptr0", ptr, 0);
    chk("bp_prio0", prio, 8'h3C);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (enq !== 1'b0 || ptr !== 8'd0 || prio !== 8'h3C) bad++;
    end
    chk("bp_stable", bad, 0);
    chk("bp_sent", sent, 0);
    ready = 1'b1;
    #1;
    chk("bp_resume_enq", enq, 1);
    chk("bp_resume_ptr", ptr, 0);
    tick();
    chk("bp_next_enq", enq, 1);
    chk("bp_next_ptr", ptr, 1);
    chk("bp_next_prio", prio, lfsr8(8'h3C));

    // Masked priorities under partial injection rate
    cfg = '{injrate: 8'h80, injrate_seed: 8'h91, prio_seed: 8'hA7,
            prio_mask: 8'h03, num_pkts: 16'd64};
    do_reset();
    ready = 1'b1;
    phase = 1'b1;
    wait_done(3000, "mask_done");
    chk("mask_count", ptr_q.size(), 64);
    ref_p = 8'hA7;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (prio_q[i] > 8'd3) bad++;
      chk($sformatf("mask_prio%0d", i), prio_q[i], ref_p & 8'h03);
      chk($sformatf("mask_ptr%0d", i), ptr_q[i], i);
      ref_p = lfsr8(ref_p);
    end
    chk("mask_range", bad, 0);

    // Empty run goes straight to DONE
    cfg.num_pkts = 16'd0;
    do_reset();
    phase = 1'b1;
    tick();
    chk("empty_done_early", done, 0);
    tick();
    chk("empty_done", done, 1);
    tick();
    chk("empty_enq_n", enq_n, 0);

    // Pause after five generated packets, then resume
    cfg = '{injrate: 8'hFF, injrate_seed: 8'h5A, prio_seed: 8'h3C,
            prio_mask: 8'hFF, num_pkts: 16'd10};
    do_reset();
    ready = 1'b1;
    phase = 1'b1;
    repeat (5) tick();
    phase = 1'b0;
    repeat (10) tick();
    chk("pause_sent", sent, 5);
    chk("pause_enq_n", enq_n, 5);
    chk("pause_done", done, 0);
    phase = 1'b1;
    wait_done(100, "pause_resume_done");
    chk("pause_count", ptr_q.size(), 10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("pause_ptr%0d", i), ptr_q[i], i);

    // Reset mid-run with a packet pending
    cfg.num_pkts = 16'd16;
    do_reset();
    ready = 1'b1;
    phase = 1'b1;
    repeat (6) tick();
    chk("mid_sent", sent, 4);
    chk("mid_pend_ptr", ptr, 4);
    reset = 1'b1;
    tick();
    chk("mid_rst_enq", enq, 0);
    chk("mid_rst_ptr", ptr, 0);
    chk("mid_rst_prio", prio, 0);
    chk("mid_rst_sent", sent, 0);
    chk("mid_rst_done", done, 0);
    reset = 1'b0;
    phase = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
